// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
`timescale 1ns/1ps
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FLUSH = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
    localparam int          INSTR_BYTES          = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_reg.sv
// Next-fetch address register: load wins over sequential increment.
`timescale 1ns/1ps
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int                 BITSIZE      = 32,
    parameter logic [BITSIZE-1:0] RESET_VECTOR = BITSIZE'(DEFAULT_RESET_VECTOR)
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_load,
    input  logic [BITSIZE-1:0] i_load_addr,
    input  logic               i_inc,
    output logic [BITSIZE-1:0] o_pc,
    output logic [BITSIZE-1:0] o_pc_next
);

    logic [BITSIZE-1:0] r_pc;

    // Increment wraps naturally at 2^BITSIZE.
    always_comb begin
        if (i_load) begin
            o_pc_next = i_load_addr;
        end else if (i_inc) begin
            o_pc_next = r_pc + BITSIZE'(INSTR_BYTES);
        end else begin
            o_pc_next = r_pc;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pc <= RESET_VECTOR;
        end else begin
            r_pc <= o_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequential fetch, consumer stall, and
// redirect/trap handling with discard of in-flight memory responses.
`timescale 1ns/1ps
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                 BITSIZE      = 32,
    parameter logic [BITSIZE-1:0] RESET_VECTOR = BITSIZE'(DEFAULT_RESET_VECTOR)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               redirect,
    input  logic [BITSIZE-1:0] redirect_target,
    input  logic               trap,
    input  logic [BITSIZE-1:0] trap_vector,
    output logic               imem_req,
    output logic [BITSIZE-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        instr,
    output logic [BITSIZE-1:0] pc,
    output logic               instr_valid,
    output logic               misaligned
);

    fetch_state_t       r_state;
    logic               r_imem_req;
    logic [BITSIZE-1:0] r_imem_addr;
    logic [31:0]        r_instr;
    logic [BITSIZE-1:0] r_pc;
    logic               r_instr_valid;
    logic               r_misaligned;

    logic               w_jump;
    logic [BITSIZE-1:0] w_target;
    logic               w_held;
    logic               w_take;
    logic [BITSIZE-1:0] w_fetch_pc;
    logic [BITSIZE-1:0] w_pc_next;

    // Trap outranks redirect; either one outranks stall and sequential fetch.
    assign w_jump   = trap | redirect;
    assign w_target = trap ? trap_vector : redirect_target;
    assign w_held   = r_instr_valid & stall;
    assign w_take   = (r_state == ST_FETCH) & imem_ack & ~w_jump & ~w_held;

    fetch_pc_reg #(
        .BITSIZE      (BITSIZE),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_fetch_pc (
        .i_clock     (clock),
        .i_reset_n   (reset_n),
        .i_load      (w_jump),
        .i_load_addr ({w_target[BITSIZE-1:2], 2'b00}),
        .i_inc       (w_take),
        .o_pc        (w_fetch_pc),
        .o_pc_next   (w_pc_next)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_imem_req    <= 1'b0;
            r_imem_addr   <= RESET_VECTOR;
            r_instr       <= NOP_INSTR;
            r_pc          <= RESET_VECTOR;
            r_instr_valid <= 1'b0;
            r_misaligned  <= 1'b0;
        end else begin
            r_misaligned <= w_jump & (w_target[1:0] != 2'b00);
            case (r_state)
                ST_IDLE: begin
                    r_state       <= ST_FETCH;
                    r_imem_req    <= 1'b1;
                    r_imem_addr   <= w_pc_next;
                    r_instr_valid <= 1'b0;
                end
                ST_FETCH: begin
                    if (w_jump) begin
                        r_instr_valid <= 1'b0;
                        r_imem_req    <= 1'b1;
                        if (imem_ack) begin
                            r_state     <= ST_FETCH;
                            r_imem_addr <= w_pc_next;
                        end else begin
                            r_state <= ST_FLUSH;
                        end
                    end else if (w_held) begin
                        // Unaccepted instruction pending: a same-cycle ack is dropped and refetched later.
                        r_state    <= ST_HOLD;
                        r_imem_req <= 1'b0;
                    end else begin
                        if (imem_ack) begin
                            r_instr       <= imem_rdata;
                            r_pc          <= w_fetch_pc;
                            r_instr_valid <= 1'b1;
                        end else begin
                            r_instr_valid <= 1'b0;
                        end
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= w_pc_next;
                    end
                end
                ST_HOLD: begin
                    if (w_jump || !stall) begin
                        r_state       <= ST_FETCH;
                        r_imem_req    <= 1'b1;
                        r_imem_addr   <= w_pc_next;
                        r_instr_valid <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    // Old request stays on the bus until its ack, whose data is thrown away.
                    if (imem_ack) begin
                        r_state     <= ST_FETCH;
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= w_pc_next;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_imem_addr;
    assign instr       = r_instr;
    assign pc          = r_pc;
    assign instr_valid = r_instr_valid;
    assign misaligned  = r_misaligned;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed cycles push expected
// instructions, a negedge monitor pops them on each accepted instruction.
`timescale 1ns/1ps
module tb_fetch_ctrl;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        trap;
    logic [31:0] trap_vector;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_valid;
    logic        misaligned;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] key      = 32'h0000_0000;
    exp_t        exp_q[$];

    fetch_ctrl dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .trap            (trap),
        .trap_vector     (trap_vector),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr           (instr),
        .pc              (pc),
        .instr_valid     (instr_valid),
        .misaligned      (misaligned)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] addr);
        exp_q.push_back('{pc: addr, instr: addr ^ key});
    endtask

    // One clock of stimulus; memory returns addr ^ key when acking.
    task automatic cyc(input logic ack, input logic stl, input logic rd, input logic [31:0] rt,
                       input logic tp, input logic [31:0] tv);
        imem_ack        = ack;
        stall           = stl;
        redirect        = rd;
        redirect_target = rt;
        trap            = tp;
        trap_vector     = tv;
        imem_rdata      = ack ? (imem_addr ^ key) : 32'hBAD0_BAD0;
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (reset_n && instr_valid && !stall) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got accepted pc %h, required no instruction", pc);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", pc, e.pc);
                check("sb_instr", instr, e.instr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_mis", {31'd0, misaligned}, 32'd0);

        // IDLE cycle: ack must be ignored
        reset_n = 1'b1;
        cyc(1, 0, 0, 0, 0, 0);
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0);
        check("first_valid", {31'd0, instr_valid}, 32'd0);

        // Sequential fetch 0,4,8
        push(32'h0); cyc(1, 0, 0, 0, 0, 0);
        push(32'h4); cyc(1, 0, 0, 0, 0, 0);
        push(32'h8); cyc(1, 0, 0, 0, 0, 0);

        // Stall three cycles with pc=8 presented
        cyc(1, 1, 0, 0, 0, 0);
        check("hold_req", {31'd0, imem_req}, 32'd0);
        check("hold_pc", pc, 32'h8);
        check("hold_instr", instr, 32'h8);
        check("hold_valid", {31'd0, instr_valid}, 32'd1);
        cyc(0, 1, 0, 0, 0, 0);
        check("hold2_req", {31'd0, imem_req}, 32'd0);
        check("hold2_pc", pc, 32'h8);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("resume_valid", {31'd0, instr_valid}, 32'd0);
        check("resume_req", {31'd0, imem_req}, 32'd1);
        check("resume_addr", imem_addr, 32'hC);
        push(32'hC); cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("accept_clears_valid", {31'd0, instr_valid}, 32'd0);

        // Redirect while waiting on 0x10, ack two cycles later
        key = 32'h5A5A_0000;
        cyc(0, 0, 1, 32'h100, 0, 0);
        check("flush_addr", imem_addr, 32'h10);
        check("flush_req", {31'd0, imem_req}, 32'd1);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("redir_addr", imem_addr, 32'h100);
        push(32'h100); cyc(1, 0, 0, 0, 0, 0);

        // Trap + redirect + ack together: trap wins, data dropped
        cyc(1, 0, 1, 32'h200, 1, 32'h80);
        check("trap_valid", {31'd0, instr_valid}, 32'd0);
        check("trap_addr", imem_addr, 32'h80);
        check("trap_mis", {31'd0, misaligned}, 32'd0);
        push(32'h80); cyc(1, 0, 0, 0, 0, 0);

        // Misaligned redirect and address wrap
        cyc(0, 0, 1, 32'hFFFF_FFFE, 0, 0);
        check("mis_pulse", {31'd0, misaligned}, 32'd1);
        check("mis_old_addr", imem_addr, 32'h84);
        cyc(1, 0, 0, 0, 0, 0);
        check("mis_cleared", {31'd0, misaligned}, 32'd0);
        check("wrap_addr_hi", imem_addr, 32'hFFFF_FFFC);
        push(32'hFFFF_FFFC); cyc(1, 0, 0, 0, 0, 0);
        check("wrap_addr_lo", imem_addr, 32'h0);
        push(32'h0); cyc(1, 0, 0, 0, 0, 0);

        // Redirect during HOLD kills the held instruction (pc=4 never accepted)
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        check("hold3_req", {31'd0, imem_req}, 32'd0);
        cyc(0, 1, 1, 32'h300, 0, 0);
        check("holdredir_valid", {31'd0, instr_valid}, 32'd0);
        check("holdredir_addr", imem_addr, 32'h300);
        push(32'h300); cyc(1, 0, 0, 0, 0, 0);

        // Second jump during FLUSH retargets but keeps the old request
        cyc(0, 0, 1, 32'h400, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'h500);
        check("flush2_addr", imem_addr, 32'h304);
        check("flush2_req", {31'd0, imem_req}, 32'd1);
        cyc(1, 0, 0, 0, 0, 0);
        check("flush2_target", imem_addr, 32'h500);

        // Reset mid-FLUSH, then a late ack in IDLE
        cyc(0, 0, 1, 32'h600, 0, 0);
        reset_n = 1'b0;
        #1;
        check("mrst_req", {31'd0, imem_req}, 32'd0);
        check("mrst_addr", imem_addr, 32'h0);
        check("mrst_pc", pc, 32'h0);
        check("mrst_instr", instr, 32'h0000_0013);
        check("mrst_valid", {31'd0, instr_valid}, 32'd0);
        cyc(0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        cyc(1, 0, 0, 0, 0, 0);
        check("mrst_fetch_addr", imem_addr, 32'h0);
        check("mrst_fetch_req", {31'd0, imem_req}, 32'd1);
        check("mrst_fetch_valid", {31'd0, instr_valid}, 32'd0);
        push(32'h0); cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
